// File: rtl/usb_rx.sv
// usb_rx: USB full-speed receiver with phase-tracking bit recovery, NRZI decode, unstuffing, SYNC/EOP and PID check.
// Define USB_RX_CRC_EN to build CRC5/CRC16 residual checking; otherwise rx_crc_err is tied low.
module usb_rx #(
   parameter int CLK_PER_BIT  = 4,
   parameter int RESET_CYCLES = 120,
   parameter int SAMPLE_PHASE = CLK_PER_BIT / 2
) (
   input  logic       clk48,
   input  logic       rst_n,
   input  logic       usb_d_p,
   input  logic       usb_d_n,
   output logic       rx_active,
   output logic       rx_sop,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_pid_ok,
   output logic       rx_eop,
   output logic       rx_err,
   output logic       rx_crc_err,
   output logic       bus_reset
);
   localparam int PW = $clog2(CLK_PER_BIT);
   localparam int RW = $clog2(RESET_CYCLES + 1);
   typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP_WAIT, DRAIN} state_t;
   state_t state_q, state_d;
   logic [1:0] meta_q, meta_d, line_q, line_d, last_q, last_d;
   logic [PW-1:0] phase_q, phase_d, ph;
   logic [RW-1:0] se0_cnt_q, se0_cnt_d;
   logic [7:0] sr_q, sr_d;
   logic [3:0] cnt_q, cnt_d;
   logic [2:0] ones_q, ones_d;
   logic lvl_q, lvl_d, first_q, first_d, err_q, err_d;
   logic active_d, sop_d, valid_d, pid_ok_d, eop_d, rx_err_d, crc_err_d, bus_reset_d;
   logic se0, j, k, chg, samp, bit_in, stuffed, crc_bad;
   assign se0     = line_q[1] == line_q[0];
   assign j       = line_q == 2'b10;
   assign k       = line_q == 2'b01;
   assign chg     = !se0 && last_q[1] != last_q[0] && line_q != last_q;
   assign ph      = chg ? '0 : phase_q;
   assign samp    = ph == PW'(SAMPLE_PHASE);
   assign bit_in  = line_q[1] == lvl_q;
   assign stuffed = ones_q == 3'd6;
   assign rx_data = sr_q;
   always_comb begin
      meta_d      = {usb_d_p, usb_d_n};
      line_d      = meta_q;
      last_d      = line_q;
      phase_d     = (ph == PW'(CLK_PER_BIT - 1)) ? '0 : ph + 1'b1;
      se0_cnt_d   = !se0 ? '0 : (se0_cnt_q == RW'(RESET_CYCLES)) ? se0_cnt_q : se0_cnt_q + 1'b1;
      bus_reset_d = se0_cnt_d == RW'(RESET_CYCLES);
      state_d     = state_q;
      lvl_d       = lvl_q;
      ones_d      = ones_q;
      cnt_d       = cnt_q;
      sr_d        = sr_q;
      first_d     = first_q;
      err_d       = err_q;
      sop_d       = 1'b0;
      valid_d     = 1'b0;
      pid_ok_d    = 1'b0;
      eop_d       = 1'b0;
      rx_err_d    = 1'b0;
      crc_err_d   = 1'b0;
      if (samp) begin
         if (!se0) lvl_d = line_q[1];
         if (!se0 && (state_q == SYNC || state_q == DATA)) ones_d = bit_in ? ones_q + 3'd1 : 3'd0;
         case (state_q)
            IDLE: begin
               lvl_d  = ~k;
               ones_d = 3'd0;
               if (k) begin
                  state_d = SYNC;
                  sr_d    = '0;
                  cnt_d   = 4'd1;
                  err_d   = 1'b0;
                  first_d = 1'b1;
               end
            end
            SYNC: begin
               if (se0) state_d = IDLE;
               else begin
                  sr_d  = {bit_in, sr_q[7:1]};
                  cnt_d = cnt_q + 4'd1;
                  if (sr_d == 8'h80) begin
                     state_d = DATA;
                     sop_d   = 1'b1;
                     cnt_d   = '0;
                  end else if (cnt_q == 4'd11) state_d = IDLE;
               end
            end
            DATA: begin
               if (se0) begin
                  state_d = EOP_WAIT;
                  err_d   = err_q | (cnt_q[2:0] != 3'd0);
               end else if (stuffed && bit_in) begin
                  state_d = DRAIN;
                  err_d   = 1'b1;
               end else if (!stuffed) begin
                  sr_d  = {bit_in, sr_q[7:1]};
                  cnt_d = {1'b0, cnt_q[2:0] + 3'd1};
                  if (cnt_q[2:0] == 3'd7) begin
                     valid_d = 1'b1;
                     first_d = 1'b0;
                     if (first_q) begin
                        pid_ok_d = sr_d[7:4] == ~sr_d[3:0];
                        err_d    = err_q | !pid_ok_d;
                     end
                  end
               end
            end
            EOP_WAIT: if (!se0) begin
               state_d   = IDLE;
               eop_d     = 1'b1;
               rx_err_d  = err_q | !j | crc_bad;
               crc_err_d = crc_bad;
            end
            DRAIN: if (se0) state_d = EOP_WAIT;
            default: state_d = IDLE;
         endcase
      end
      // a qualified bus reset silently abandons any packet in flight
      if (bus_reset_d) state_d = IDLE;
      active_d = state_d == DATA || state_d == EOP_WAIT;
   end
`ifdef USB_RX_CRC_EN
   logic [4:0] crc5_q, crc5_d;
   logic [15:0] crc16_q, crc16_d;
   logic [1:0] pid_type_q, pid_type_d;
   logic data_bit;
   assign data_bit = samp && state_q == DATA && !se0 && !stuffed && !first_q;
   always_comb begin
      crc5_d     = crc5_q;
      crc16_d    = crc16_q;
      pid_type_d = pid_type_q;
      if (sop_d) begin
         crc5_d     = '1;
         crc16_d    = '1;
         pid_type_d = 2'b10;
      end else if (data_bit) begin
         crc5_d  = {crc5_q[3:0], 1'b0} ^ ((bit_in ^ crc5_q[4]) ? 5'h05 : 5'h00);
         crc16_d = {crc16_q[14:0], 1'b0} ^ ((bit_in ^ crc16_q[15]) ? 16'h8005 : 16'h0000);
      end
      if (valid_d && first_q) pid_type_d = sr_d[1:0];
   end
   always_ff @(posedge clk48 or negedge rst_n) begin
      if (!rst_n) begin
         crc5_q     <= '1;
         crc16_q    <= '1;
         pid_type_q <= 2'b10;
      end else begin
         crc5_q     <= crc5_d;
         crc16_q    <= crc16_d;
         pid_type_q <= pid_type_d;
      end
   end
   assign crc_bad = (pid_type_q == 2'b01 && crc5_q != 5'b01100) ||
                    (pid_type_q == 2'b11 && crc16_q != 16'h800D);
`else
   assign crc_bad = 1'b0;
`endif
   always_ff @(posedge clk48 or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         meta_q     <= 2'b10;
         line_q     <= 2'b10;
         last_q     <= 2'b10;
         phase_q    <= '0;
         se0_cnt_q  <= '0;
         sr_q       <= '0;
         cnt_q      <= '0;
         ones_q     <= '0;
         lvl_q      <= 1'b1;
         first_q    <= 1'b0;
         err_q      <= 1'b0;
         rx_active  <= 1'b0;
         rx_sop     <= 1'b0;
         rx_valid   <= 1'b0;
         rx_pid_ok  <= 1'b0;
         rx_eop     <= 1'b0;
         rx_err     <= 1'b0;
         rx_crc_err <= 1'b0;
         bus_reset  <= 1'b0;
      end else begin
         state_q    <= state_d;
         meta_q     <= meta_d;
         line_q     <= line_d;
         last_q     <= last_d;
         phase_q    <= phase_d;
         se0_cnt_q  <= se0_cnt_d;
         sr_q       <= sr_d;
         cnt_q      <= cnt_d;
         ones_q     <= ones_d;
         lvl_q      <= lvl_d;
         first_q    <= first_d;
         err_q      <= err_d;
         rx_active  <= active_d;
         rx_sop     <= sop_d;
         rx_valid   <= valid_d;
         rx_pid_ok  <= pid_ok_d;
         rx_eop     <= eop_d;
         rx_err     <= rx_err_d;
         rx_crc_err <= crc_err_d;
         bus_reset  <= bus_reset_d;
      end
   end
endmodule

// File: tb/tb_usb_rx.sv
// tb_usb_rx: directed packets driven through an NRZI/bit-stuffing line encoder, with hand-computed expectations.
module tb_usb_rx;
   localparam int CPB = 4;
   localparam int RST_CYC = 120;
   logic clk48 = 1'b0, rst_n = 1'b0, usb_d_p = 1'b1, usb_d_n = 1'b0;
   logic rx_active, rx_sop, rx_valid, rx_pid_ok, rx_eop, rx_err, rx_crc_err, bus_reset;
   logic [7:0] rx_data;
   int errs = 0, checks = 0;
   int sop_n = 0, eop_n = 0, tx_ones = 0;
   logic pid_ok_seen = 1'b0, eop_err = 1'b0, eop_crc = 1'b0;
   logic [7:0] bytes[$];
   logic tx_lvl = 1'b1, stuff_en = 1'b1, jit = 1'b0, alt = 1'b0;

   usb_rx #(.CLK_PER_BIT(CPB), .RESET_CYCLES(RST_CYC)) dut (
      .clk48(clk48), .rst_n(rst_n), .usb_d_p(usb_d_p), .usb_d_n(usb_d_n),
      .rx_active(rx_active), .rx_sop(rx_sop), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_pid_ok(rx_pid_ok), .rx_eop(rx_eop), .rx_err(rx_err), .rx_crc_err(rx_crc_err),
      .bus_reset(bus_reset)
   );

   always #5 clk48 = ~clk48;

   always @(negedge clk48) begin
      if (rx_sop) sop_n++;
      if (rx_valid) begin
         if (bytes.size() == 0) pid_ok_seen = rx_pid_ok;
         bytes.push_back(rx_data);
      end
      if (rx_eop) begin
         eop_n++;
         eop_err = rx_err;
         eop_crc = rx_crc_err;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic hold(input logic p, input logic n, input int cyc);
      usb_d_p = p;
      usb_d_n = n;
      repeat (cyc) @(negedge clk48);
   endtask

   task automatic tx_raw(input logic b);
      int cyc;
      cyc = jit ? (alt ? 3 : 5) : CPB;
      alt = ~alt;
      if (!b) tx_lvl = ~tx_lvl;
      hold(tx_lvl, ~tx_lvl, cyc);
   endtask

   task automatic tx_bit(input logic b);
      tx_raw(b);
      tx_ones = b ? tx_ones + 1 : 0;
      if (stuff_en && tx_ones == 6) begin
         tx_raw(1'b0);
         tx_ones = 0;
      end
   endtask

   task automatic tx_byte(input logic [7:0] v);
      for (int i = 0; i < 8; i++) tx_bit(v[i]);
   endtask

   task automatic tx_sync();
      tx_lvl  = 1'b1;
      tx_ones = 0;
      tx_byte(8'h80);
   endtask

   task automatic tx_eop();
      hold(1'b0, 1'b0, 2 * CPB);
      tx_lvl = 1'b1;
      hold(1'b1, 1'b0, CPB + 10);
   endtask

   task automatic clr();
      sop_n = 0;
      eop_n = 0;
      bytes.delete();
      pid_ok_seen = 1'b0;
      eop_err = 1'b0;
      eop_crc = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge clk48);
      check("reset_outs", {rx_active, rx_sop, rx_valid, rx_pid_ok, rx_eop, rx_err, rx_crc_err, bus_reset, rx_data}, 0);
      rst_n = 1'b1;
      repeat (20) @(negedge clk48);

      clr(); tx_sync(); tx_byte(8'hD2); tx_eop();
      check("ack_sop", sop_n, 1);
      check("ack_nbytes", bytes.size(), 1);
      check("ack_data", bytes[0], 8'hD2);
      check("ack_pid_ok", pid_ok_seen, 1);
      check("ack_eop", eop_n, 1);
      check("ack_err", eop_err, 0);
      check("ack_active_after", rx_active, 0);

      clr(); tx_sync(); tx_byte(8'hD2); tx_byte(8'hFF); tx_byte(8'h3F); tx_eop();
      check("stuff_nbytes", bytes.size(), 3);
      check("stuff_b1", bytes[1], 8'hFF);
      check("stuff_b2", bytes[2], 8'h3F);
      check("stuff_err", eop_err, 0);

      clr(); tx_sync(); tx_byte(8'hD2);
      stuff_en = 1'b0;
      for (int i = 0; i < 7; i++) tx_bit(1'b1);
      stuff_en = 1'b1;
      tx_eop();
      check("stufferr_nbytes", bytes.size(), 1);
      check("stufferr_eop", eop_n, 1);
      check("stufferr_err", eop_err, 1);

      clr(); tx_sync(); tx_byte(8'hD3); tx_eop();
      check("badpid_pid_ok", pid_ok_seen, 0);
      check("badpid_err", eop_err, 1);

      clr(); tx_sync(); tx_byte(8'hD2); tx_bit(1'b1); tx_bit(1'b0); tx_bit(1'b1); tx_eop();
      check("align_eop", eop_n, 1);
      check("align_err", eop_err, 1);

      clr(); tx_sync(); tx_byte(8'hD2); tx_bit(1'b0); tx_bit(1'b1); tx_bit(1'b0);
      check("busrst_active_before", rx_active, 1);
      hold(1'b0, 1'b0, RST_CYC + 2);
      check("busrst_high", bus_reset, 1);
      check("busrst_active", rx_active, 0);
      hold(1'b0, 1'b0, 8);
      hold(1'b1, 1'b0, 3);
      check("busrst_fall", bus_reset, 0);
      hold(1'b1, 1'b0, 20);
      check("busrst_no_eop", eop_n, 0);

      clr(); hold(1'b0, 1'b1, CPB); hold(1'b0, 1'b0, 2 * CPB); hold(1'b1, 1'b0, 20);
      check("abort_sop", sop_n, 0);
      check("abort_eop", eop_n, 0);

      clr(); jit = 1'b1; alt = 1'b0;
      tx_sync(); tx_byte(8'h69);
      jit = 1'b0;
      tx_eop();
      check("jitter_nbytes", bytes.size(), 1);
      check("jitter_data", bytes[0], 8'h69);
      check("jitter_pid_ok", pid_ok_seen, 1);

      clr(); tx_sync(); tx_byte(8'hD2); tx_bit(1'b1); tx_bit(1'b1);
      check("rstn_active_before", rx_active, 1);
      rst_n = 1'b0;
      #1;
      check("rstn_outs", {rx_active, rx_sop, rx_valid, rx_pid_ok, rx_eop, rx_err, rx_crc_err, bus_reset, rx_data}, 0);
      hold(1'b1, 1'b0, 10);
      rst_n = 1'b1;
      hold(1'b1, 1'b0, 20);
      check("rstn_no_eop", eop_n, 0);

`ifdef USB_RX_CRC_EN
      clr(); tx_sync(); tx_byte(8'hE1); tx_byte(8'h00); tx_byte(8'h10); tx_eop();
      check("crc_ok_crc", eop_crc, 0);
      check("crc_ok_err", eop_err, 0);
      clr(); tx_sync(); tx_byte(8'hE1); tx_byte(8'h00); tx_byte(8'h11); tx_eop();
      check("crc_bad_crc", eop_crc, 1);
      check("crc_bad_err", eop_err, 1);
`endif

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
